// File: rtl/wptr_full_prog.sv
// Write-side pointer and full-flag generator for the dual-clock FIFO.
// Keeps binary and Gray write pointers in the wclk domain. Compares them
// against the synchronised Gray read pointer to produce full, programmable
// almost-full, fill level and a sticky overflow error.
// Optional feature macro: WPTR_OVF_ERR_EN (sticky overflow flag with clear).
module wptr_full_prog #(
    parameter int ADDRSIZE = 8
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                werr_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wfull_almost,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                fifo_error_w
);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] lvl_next;
    logic              wpush;
    logic              wfull_val;
    logic              wfull_almost_val;

    // Writes are refused while full; the pointer holds on a refused write.
    always_comb begin
        wpush     = winc & ~wfull;
        wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wpush};
        wgraynext = (wbinnext >> 1) ^ wbinnext;
    end

    // Gray-to-binary conversion of the synchronised read pointer, MSB down.
    always_comb begin
        rbin_s = '0;
        rbin_s[ADDRSIZE] = wq2_rptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
        end
    end

    // Level and flags for the next state; the extra pointer MSB separates
    // full from empty, so the subtraction wraps naturally.
    always_comb begin
        lvl_next         = wbinnext - rbin_s;
        wfull_val        = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                          wq2_rptr[ADDRSIZE-2:0]});
        wfull_almost_val = (lvl_next >= afull_thresh);
    end

    // Pointer, level and flag registers, all updated every write-clock edge.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wlevel       <= '0;
            wfull        <= 1'b0;
            wfull_almost <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wlevel       <= lvl_next;
            wfull        <= wfull_val;
            wfull_almost <= wfull_almost_val;
        end
    end

    assign waddr = wbin[ADDRSIZE-1:0];

`ifdef WPTR_OVF_ERR_EN
    // Sticky overflow flag; a new overflow wins over a same-cycle clear.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            fifo_error_w <= 1'b0;
        end else begin
            fifo_error_w <= (fifo_error_w & ~werr_clr) | (winc & wfull);
        end
    end
`else
    logic unused_werr_clr;
    assign unused_werr_clr = werr_clr;
    assign fifo_error_w    = 1'b0;
`endif

endmodule

// File: doc/wptr_full_prog.md
# wptr_full_prog

Write-side pointer and full-flag generator for the dual-clock FIFO, parametrised successor to the fixed write-pointer block. It runs entirely in the write clock domain. It keeps a binary and a Gray write pointer and compares them against the synchronised Gray read pointer. From that comparison it produces the registered full flag, a runtime-programmable almost-full flag, a free-running fill level and a sticky overflow error.

## Interface
- ADDRSIZE, 8, address width; FIFO depth DEPTH = 2**ADDRSIZE; legal range 2..16
- wclk  in  1  write clock; all state updates on its rising edge
- wrst  in  1  reset, synchronous, active-high; sampled on the rising edge of wclk
- winc  in  1  write request
- wq2_rptr  in  ADDRSIZE+1  read pointer in Gray code, already two-flop synchronised into wclk
- afull_thresh  in  ADDRSIZE+1  almost-full threshold in entries; quasi-static
- werr_clr  in  1  clears fifo_error_w
- waddr  out  ADDRSIZE  RAM write address, equal to wbin[ADDRSIZE-1:0]
- wptr  out  ADDRSIZE+1  Gray write pointer, registered, for the read-side synchroniser
- wfull  out  1  FIFO full, registered
- wfull_almost  out  1  level at or above afull_thresh, registered
- wlevel  out  ADDRSIZE+1  occupied entries as seen from the write side, 0..DEPTH, registered
- fifo_error_w  out  1  sticky overflow flag, registered

## Operation
- Write acceptance:
  - wpush = winc & ~wfull.
  - wbinnext = wbin + wpush, modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
- Read pointer conversion: rbin_s = Gray-to-binary(wq2_rptr), combinational, MSB-down XOR chain.
- Level: lvl_next = wbinnext - rbin_s, modulo 2**(ADDRSIZE+1). Its value is always in 0..DEPTH.
- Full flag:
  - wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - This is equivalent to lvl_next == DEPTH. Both forms must agree; the bench checks this.
- Almost-full flag:
  - wfull_almost_val = (lvl_next >= afull_thresh), unsigned compare.
  - afull_thresh = 0 gives a constant 1.
  - afull_thresh > DEPTH gives a constant 0.
- Registers loaded every edge when wrst = 0:
  - wbin <= wbinnext
  - wptr <= wgraynext
  - wlevel <= lvl_next
  - wfull <= wfull_val
  - wfull_almost <= wfull_almost_val
- Overflow: winc while wfull = 1 drops the write. wbin and wptr hold their values.
- Error flag: fifo_error_w <= (fifo_error_w & ~werr_clr) | (winc & wfull). When set and clear occur in the same cycle, set wins.
- Conservative behaviour: wq2_rptr lags the true read pointer by 2+ wclk cycles, so wlevel, wfull and wfull_almost may overstate occupancy. They never understate it. Full deasserts only after a read pointer change has been synchronised.
- Wrap-around: pointers wrap from 2**(ADDRSIZE+1)-1 to 0 without special handling. The extra MSB distinguishes full from empty.

## Timing
- Reset: when wrst = 1 at an edge, the following are 0 after that edge, regardless of winc and werr_clr:
  - wbin, wptr, waddr, wlevel, wfull, wfull_almost, fifo_error_w
- The first edge with wrst = 0 evaluates normally.
- Reset mid-operation discards the pointer. The read side must be reset in the same window, since this block does not re-align to wq2_rptr.
- Latency: a write accepted at edge N advances waddr, wptr and wlevel at edge N.
- wfull rises at the same edge as the write that fills the last entry, so the next cycle's winc is refused.
- wfull_almost updates at the same edge as the write that crosses the threshold.
- A change on wq2_rptr that is stable before edge N is reflected in wlevel, wfull and wfull_almost after edge N. No additional pipeline stage is added.
- afull_thresh changes take effect at the next edge. Glitch-free behaviour is not required.

## Configuration
- WPTR_OVF_ERR_EN:
  - Defined: the fifo_error_w register and the werr_clr logic exist as described.
  - Undefined: fifo_error_w is tied to 0 and werr_clr is ignored.
  - Undefined: overflow writes are still dropped.

## Test plan
- Reset:
  - Stimulus: ADDRSIZE = 4, hold wrst = 1 for 3 edges with winc = 1.
  - Required: all outputs 0 and wptr = 5'b00000 throughout.
- Fill:
  - Stimulus: wq2_rptr = 0, afull_thresh = 12, 16 consecutive winc.
  - Required: wlevel steps 1..16; wfull_almost rises at the edge of write 12; wfull rises at the edge of write 16; wptr = 5'b11000.
- Overflow:
  - Stimulus: from full, 3 more winc.
  - Required: waddr stays 0, wptr stays 5'b11000, fifo_error_w = 1 from the first refused edge.
  - Stimulus: werr_clr pulse together with winc.
  - Required: the flag stays 1.
  - Stimulus: werr_clr alone.
  - Required: the flag clears to 0.
- Drain and wrap:
  - Stimulus: step wq2_rptr as Gray 1..31 with interleaved writes.
  - Required: wbin crosses 31 -> 0, wlevel always equals the model level, and wfull never asserts while wlevel < 16.
- Threshold edges:
  - Stimulus: afull_thresh = 0.
  - Required: wfull_almost = 1 from the first edge after reset.
  - Stimulus: afull_thresh = 17.
  - Required: wfull_almost = 0 even when full.
- Macro off:
  - Stimulus: repeat the overflow test with WPTR_OVF_ERR_EN undefined.
  - Required: fifo_error_w = 0 and the pointers still hold.
